stream_dma_writer: RTL and testbench
====================================

STREAM_DMA_WRITER -- requirements
Module: stream_dma_writer

Interface
REQ-001 Parameter DATA_W, 128, width of FIFO and SDRAM data words.
REQ-002 Parameter ADDR_W, 28, SDRAM word-address width.
REQ-003 Parameter MAX_BURST, 8, maximum Avalon burst length in words; power of two, 1..64.
REQ-004 Parameter CNT_W, 11, width of FIFO fill count.
REQ-005 Parameter DONE_W, 16, width of DONE_CNT.
REQ-006 Ports: CLK in 1 single clock; RST_N in 1 asynchronous active-low reset. This is already decided.
REQ-007 START_ADR in ADDR_W ring base word address; BUF_SIZE in ADDR_W ring size in words; START in 1 arm pulse; STOP in 1 stop request; CONTINUOUS in 1 ring mode (1) or one-shot (0).
REQ-008 BUSY out 1 engine active; DONE_CNT out DONE_W completed buffer passes; CFG_ERR out 1 sticky, START seen with BUF_SIZE=0.
REQ-009 FIFO_DATA in DATA_W show-ahead head word; FIFO_EMPTY in 1; FIFO_RD_CNT in CNT_W words available; FIFO_RD_EN out 1 pop.
REQ-010 SDRAM_ADDRESS out ADDR_W; SDRAM_BURSTCOUNT out 7; SDRAM_WRITEDATA out DATA_W; SDRAM_WRITE out 1; SDRAM_WAITREQUEST in 1.

Function
REQ-011 States: IDLE, ARM, WAIT_DATA, BURST, CHECK.
REQ-012 IDLE: START=1 with BUF_SIZE!=0 -> ARM, latches START_ADR, BUF_SIZE, CONTINUOUS, clears offset; BUF_SIZE=0 sets CFG_ERR and stays in IDLE.
REQ-013 ARM -> WAIT_DATA after one cycle; BUSY=1 in every state except IDLE.
REQ-014 WAIT_DATA: burst length L = min(MAX_BURST, BUF_SIZE-offset); when FIFO_RD_CNT>=L, register SDRAM_ADDRESS=base+offset and SDRAM_BURSTCOUNT=L, then go to BURST.
REQ-015 BURST: SDRAM_WRITE=1; a beat is accepted on a cycle with SDRAM_WRITE=1 and SDRAM_WAITREQUEST=0.
REQ-016 FIFO_RD_EN = SDRAM_WRITE & ~SDRAM_WAITREQUEST (combinational); SDRAM_WRITEDATA = FIFO_DATA (combinational).
REQ-017 SDRAM_ADDRESS and SDRAM_BURSTCOUNT stay constant for the whole burst.
REQ-018 After the L-th accepted beat: SDRAM_WRITE drops on the next cycle, offset += L, go to CHECK.
REQ-019 CHECK, offset==BUF_SIZE: DONE_CNT += 1 (wraps modulo 2^DONE_W), offset=0; CONTINUOUS=1 -> WAIT_DATA; CONTINUOUS=0 -> IDLE.
REQ-020 CHECK, offset<BUF_SIZE: go to WAIT_DATA.
REQ-021 A burst never crosses the ring end; if BUF_SIZE is not a multiple of MAX_BURST, the last burst is shortened.
REQ-022 STOP is latched as pending; a burst in progress completes; in WAIT_DATA or CHECK with STOP pending -> IDLE, clear pending. DONE_CNT is not incremented unless the pass completed.
REQ-023 START while BUSY=1 is ignored.
REQ-024 STOP in IDLE is ignored.
REQ-025 Address sums are computed modulo 2^ADDR_W.
REQ-026 Latency: START to first SDRAM_WRITE is 3 cycles minimum with the FIFO already sufficiently full.

Reset
REQ-027 RST_N=0 asynchronously forces IDLE with SDRAM_WRITE=0, FIFO_RD_EN=0, BUSY=0, DONE_CNT=0, CFG_ERR=0, SDRAM_ADDRESS=0, SDRAM_BURSTCOUNT=0, offset=0 and STOP pending cleared.
REQ-028 Reset mid-burst abandons the burst; no further beats are issued after reset is released until a new START.

Configuration
REQ-029 Macro DMA_WR_STATS_EN is defined: adds output STALL_CNT, 32 bits, counting cycles with SDRAM_WRITE=1 and SDRAM_WAITREQUEST=1; it saturates at all-ones and clears on reset or on an accepted START.
REQ-030 Macro DMA_WR_STATS_EN is undefined: no STALL_CNT port and no counter logic.

Structure
REQ-031 Shared package dma_pkg holds the state enum, the BURSTCOUNT width constant (7) and the MAX_BURST legality check.
REQ-032 One sub-module, dma_burst_sizer: combinational computation of L and the next-offset value from offset, BUF_SIZE and MAX_BURST.

Verification
REQ-033 BUF_SIZE=32, MAX_BURST=8, CONTINUOUS=0, FIFO holds 32, no waitrequest -> 4 bursts at base+0, +8, +16, +24, each with BURSTCOUNT=8; DONE_CNT=1; BUSY returns to 0.
REQ-034 BUF_SIZE=20, MAX_BURST=8, CONTINUOUS=1, 60 words supplied -> burst lengths 8,8,4,8,8,4,8,8,4; address returns to base after each 4-word burst; DONE_CNT=3.
REQ-035 Random SDRAM_WAITREQUEST at 50% -> address and burstcount held stable, FIFO_RD_EN asserted only on accepted beats, data order preserved; with the macro defined, STALL_CNT equals the number of waited cycles.
REQ-036 STOP asserted in the 3rd beat of the 2nd burst -> burst completes (8 beats), then IDLE; DONE_CNT unchanged.
REQ-037 START with BUF_SIZE=0 -> CFG_ERR=1, BUSY=0, no writes issued.
REQ-038 RST_N pulled low in the 5th beat -> SDRAM_WRITE=0 in the same cycle and all outputs at reset values; no writes issued after release until a new START.

Source files
------------

// File: rtl/dma_pkg.sv
// ============================================================================
// Module   : dma_pkg
// Brief    : Shared types and constants for the stream DMA writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dma_pkg;

    localparam int BCNT_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_BURST     = 3'd3,
        ST_CHECK     = 3'd4
    } state_t;

    function automatic bit max_burst_ok(input int mb);
        return (mb >= 1) && (mb <= 64) && ((mb & (mb - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_dma_writer_if.sv
// ============================================================================
// Module   : stream_dma_writer_if
// Brief    : FIFO read port and Avalon-MM burst write port of the DMA writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface stream_dma_writer_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 28,
    parameter int CNT_W  = 11
);
    logic [DATA_W-1:0]          FIFO_DATA;
    logic                       FIFO_EMPTY;
    logic [CNT_W-1:0]           FIFO_RD_CNT;
    logic                       FIFO_RD_EN;
    logic [ADDR_W-1:0]          SDRAM_ADDRESS;
    logic [dma_pkg::BCNT_W-1:0] SDRAM_BURSTCOUNT;
    logic [DATA_W-1:0]          SDRAM_WRITEDATA;
    logic                       SDRAM_WRITE;
    logic                       SDRAM_WAITREQUEST;

    modport master (
        input  FIFO_DATA, FIFO_EMPTY, FIFO_RD_CNT, SDRAM_WAITREQUEST,
        output FIFO_RD_EN, SDRAM_ADDRESS, SDRAM_BURSTCOUNT, SDRAM_WRITEDATA, SDRAM_WRITE
    );

    modport slave (
        output FIFO_DATA, FIFO_EMPTY, FIFO_RD_CNT, SDRAM_WAITREQUEST,
        input  FIFO_RD_EN, SDRAM_ADDRESS, SDRAM_BURSTCOUNT, SDRAM_WRITEDATA, SDRAM_WRITE
    );
endinterface

`default_nettype wire

// File: rtl/dma_burst_sizer.sv
// ============================================================================
// Module   : dma_burst_sizer
// Brief    : Burst length (clipped at the ring end) and post-burst offset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dma_burst_sizer
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int MAX_BURST = 8
) (
    input  wire logic [ADDR_W-1:0] offset_i,
    input  wire logic [ADDR_W-1:0] size_i,
    output logic      [BCNT_W-1:0] len_o,
    output logic      [ADDR_W-1:0] next_off_o
);
    localparam logic [ADDR_W-1:0] c_max = ADDR_W'(MAX_BURST);

    logic [ADDR_W-1:0] w_rem;

    always_comb begin
        w_rem = size_i - offset_i;
        if (w_rem < c_max) begin
            len_o = w_rem[BCNT_W-1:0];
        end else begin
            len_o = BCNT_W'(MAX_BURST);
        end
        next_off_o = offset_i + ADDR_W'(len_o);
    end
endmodule

`default_nettype wire

// File: rtl/stream_dma_writer.sv
// ============================================================================
// Module   : stream_dma_writer
// Brief    : Drains a show-ahead FIFO into an SDRAM ring with Avalon bursts.
//            Optional macro DMA_WR_STATS_EN adds the STALL_CNT output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_dma_writer
    import dma_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 28,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 11,
    parameter int DONE_W    = 16
) (
    input  wire logic              CLK,
    input  wire logic              RST_N,
    input  wire logic [ADDR_W-1:0] START_ADR,
    input  wire logic [ADDR_W-1:0] BUF_SIZE,
    input  wire logic              START,
    input  wire logic              STOP,
    input  wire logic              CONTINUOUS,
    output logic                   BUSY,
    output logic      [DONE_W-1:0] DONE_CNT,
    output logic                   CFG_ERR,
`ifdef DMA_WR_STATS_EN
    output logic      [31:0]       STALL_CNT,
`endif
    stream_dma_writer_if.master    bus
);
    localparam int c_cmp_w = (CNT_W > BCNT_W) ? CNT_W : BCNT_W;

    if (!max_burst_ok(MAX_BURST)) begin : g_bad_max_burst
        $error("MAX_BURST must be a power of two in 1..64");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d, size_q, size_d, offset_q, offset_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d, beat_q, beat_d;
    logic [DONE_W-1:0]   done_q, done_d;
    logic                cont_q, cont_d, stop_pend_q, stop_pend_d, cfg_err_q, cfg_err_d;

    logic [BCNT_W-1:0]   w_len;
    logic [ADDR_W-1:0]   w_next_off;
    logic                w_write, w_accept, w_last, w_start_acc, w_data_ok;

    dma_burst_sizer #(
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST)
    ) u_sizer (
        .offset_i   (offset_q),
        .size_i     (size_q),
        .len_o      (w_len),
        .next_off_o (w_next_off)
    );

    assign w_write   = (state_q == ST_BURST);
    assign w_accept  = w_write & ~bus.SDRAM_WAITREQUEST;
    assign w_last    = w_accept && ((beat_q + 7'd1) == bcnt_q);
    assign w_data_ok = ~bus.FIFO_EMPTY && (c_cmp_w'(bus.FIFO_RD_CNT) >= c_cmp_w'(w_len));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        size_d      = size_q;
        cont_d      = cont_q;
        offset_d    = offset_q;
        addr_d      = addr_q;
        bcnt_d      = bcnt_q;
        beat_d      = beat_q;
        done_d      = done_q;
        cfg_err_d   = cfg_err_q;
        stop_pend_d = stop_pend_q | (STOP && (state_q != ST_IDLE));
        w_start_acc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (BUF_SIZE == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        w_start_acc = 1'b1;
                        base_d      = START_ADR;
                        size_d      = BUF_SIZE;
                        cont_d      = CONTINUOUS;
                        offset_d    = '0;
                        state_d     = ST_ARM;
                    end
                end
            end
            ST_ARM: state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                if (stop_pend_q) begin
                    state_d = ST_IDLE;
                end else if (w_data_ok) begin
                    addr_d  = base_q + offset_q;
                    bcnt_d  = w_len;
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_accept) begin
                    beat_d = beat_q + 7'd1;
                    if (w_last) begin
                        offset_d = w_next_off;
                        state_d  = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (offset_q == size_q) begin
                    done_d   = done_q + 1'b1;
                    offset_d = '0;
                end
                if (stop_pend_q) begin
                    state_d = ST_IDLE;
                end else if ((offset_q != size_q) || cont_q) begin
                    state_d = ST_WAIT_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stop that lands on the way back to IDLE must not leak into the next run.
        if (state_d == ST_IDLE) begin
            stop_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            size_q      <= '0;
            cont_q      <= 1'b0;
            offset_q    <= '0;
            addr_q      <= '0;
            bcnt_q      <= '0;
            beat_q      <= '0;
            done_q      <= '0;
            cfg_err_q   <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            size_q      <= size_d;
            cont_q      <= cont_d;
            offset_q    <= offset_d;
            addr_q      <= addr_d;
            bcnt_q      <= bcnt_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            stop_pend_q <= stop_pend_d;
        end
    end

`ifdef DMA_WR_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_q <= '0;
        end else if (w_start_acc) begin
            stall_q <= '0;
        end else if (w_write && bus.SDRAM_WAITREQUEST && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign STALL_CNT = stall_q;
`endif

    assign BUSY                 = (state_q != ST_IDLE);
    assign DONE_CNT             = done_q;
    assign CFG_ERR              = cfg_err_q;
    assign bus.SDRAM_WRITE      = w_write;
    assign bus.FIFO_RD_EN       = w_accept;
    assign bus.SDRAM_WRITEDATA  = bus.FIFO_DATA;
    assign bus.SDRAM_ADDRESS    = addr_q;
    assign bus.SDRAM_BURSTCOUNT = bcnt_q;
endmodule

`default_nettype wire

// File: tb/tb_stream_dma_writer.sv
// ============================================================================
// Module   : tb_stream_dma_writer
// Brief    : Directed self-checking bench for stream_dma_writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_dma_writer;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [27:0] START_ADR = '0;
    logic [27:0] BUF_SIZE = '0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        CONTINUOUS = 1'b0;
    logic        BUSY;
    logic [15:0] DONE_CNT;
    logic        CFG_ERR;
`ifdef DMA_WR_STATS_EN
    logic [31:0] stall_cnt;
`endif

    stream_dma_writer_if #(.DATA_W(128), .ADDR_W(28), .CNT_W(11)) bus ();

    stream_dma_writer dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START_ADR  (START_ADR),
        .BUF_SIZE   (BUF_SIZE),
        .START      (START),
        .STOP       (STOP),
        .CONTINUOUS (CONTINUOUS),
        .BUSY       (BUSY),
        .DONE_CNT   (DONE_CNT),
        .CFG_ERR    (CFG_ERR),
`ifdef DMA_WR_STATS_EN
        .STALL_CNT  (stall_cnt),
`endif
        .bus        (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] fifo_q[$];
    logic [27:0]  log_addr[$];
    logic [6:0]   log_len[$];
    int unsigned  push_val = 32'h1000;
    int unsigned  exp_val  = 32'h1000;
    int           beats, stalls, stab_err, rden_err, data_err;
    logic         in_burst = 1'b0;
    logic [27:0]  b_addr;
    logic [6:0]   b_len;
    logic         pop_req = 1'b0;
    logic         wr_rand = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void refresh_fifo();
        bus.FIFO_DATA   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        bus.FIFO_EMPTY  = (fifo_q.size() == 0);
        bus.FIFO_RD_CNT = 11'(fifo_q.size());
    endfunction

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back({4{push_val}});
            push_val++;
        end
        refresh_fifo();
    endtask

    task automatic flush_fifo();
        fifo_q.delete();
        exp_val = push_val;
        refresh_fifo();
    endtask

    task automatic clear_stats();
        beats = 0; stalls = 0; stab_err = 0; rden_err = 0; data_err = 0;
        log_addr.delete();
        log_len.delete();
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic start_dma(input logic [27:0] adr, input logic [27:0] size, input logic cont);
        START_ADR  = adr;
        BUF_SIZE   = size;
        CONTINUOUS = cont;
        START      = 1'b1;
        tick();
        START      = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (BUSY && n < max_cyc) begin
            tick();
            n++;
        end
        chk("idle_timeout", BUSY, 1'b0);
    endtask

    // FIFO pop and waitrequest update happen just after the edge the DUT sampled.
    always begin
        @(posedge CLK);
        #1;
        if (pop_req) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_req = 1'b0;
        end
        bus.SDRAM_WAITREQUEST = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        refresh_fifo();
    end

    always @(negedge CLK) begin
        if (!RST_N) begin
            in_burst = 1'b0;
        end else begin
            if (bus.FIFO_RD_EN !== (bus.SDRAM_WRITE & ~bus.SDRAM_WAITREQUEST)) rden_err++;
            if (bus.SDRAM_WRITE) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    b_addr   = bus.SDRAM_ADDRESS;
                    b_len    = bus.SDRAM_BURSTCOUNT;
                    log_addr.push_back(b_addr);
                    log_len.push_back(b_len);
                end else if (bus.SDRAM_ADDRESS !== b_addr || bus.SDRAM_BURSTCOUNT !== b_len) begin
                    stab_err++;
                end
                if (bus.SDRAM_WAITREQUEST) stalls++;
                if (!bus.SDRAM_WAITREQUEST) begin
                    if (bus.SDRAM_WRITEDATA !== {4{exp_val}}) data_err++;
                    exp_val++;
                    beats++;
                    pop_req = 1'b1;
                end
            end else begin
                in_burst = 1'b0;
            end
        end
    end

    initial begin
        int n;
        logic [27:0] ring_base;
        bus.SDRAM_WAITREQUEST = 1'b0;
        refresh_fifo();
        clear_stats();

        // Reset state
        #3;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_write", bus.SDRAM_WRITE, 1'b0);
        chk("rst_rden", bus.FIFO_RD_EN, 1'b0);
        chk("rst_done", DONE_CNT, 16'd0);
        chk("rst_cfgerr", CFG_ERR, 1'b0);
        chk("rst_addr", bus.SDRAM_ADDRESS, 28'd0);
        chk("rst_bcnt", bus.SDRAM_BURSTCOUNT, 7'd0);
        repeat (3) tick();
        RST_N = 1'b1;
        tick();

        // One-shot 32-word buffer, four full bursts, plus start latency
        clear_stats();
        push_words(32);
        START_ADR = 28'h100; BUF_SIZE = 28'd32; CONTINUOUS = 1'b0; START = 1'b1;
        n = 0;
        do begin
            tick();
            START = 1'b0;
            n++;
        end while (!bus.SDRAM_WRITE && n < 20);
        chk("t1_latency", n, 3);
        wait_idle(500);
        chk("t1_bursts", log_addr.size(), 4);
        for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
            chk($sformatf("t1_addr%0d", k), log_addr[k], 28'h100 + 28'(8 * k));
            chk($sformatf("t1_len%0d", k), log_len[k], 7'd8);
        end
        chk("t1_beats", beats, 32);
        chk("t1_data", data_err, 0);
        chk("t1_done", DONE_CNT, 16'd1);

        // Continuous 20-word ring, base near the top of the address space
        clear_stats();
        ring_base = 28'hFFFFFF8;
        push_words(60);
        start_dma(ring_base, 28'd20, 1'b1);
        n = 0;
        while (!(log_len.size() >= 9 && !bus.SDRAM_WRITE) && n < 1000) begin
            tick();
            n++;
        end
        repeat (5) tick();
        chk("t2_bursts", log_len.size(), 9);
        for (int k = 0; k < 9 && k < log_len.size(); k++) begin
            chk($sformatf("t2_len%0d", k), log_len[k], (k % 3 == 2) ? 7'd4 : 7'd8);
            chk($sformatf("t2_addr%0d", k), log_addr[k], 28'(ring_base + 28'((k % 3) * 8)));
        end
        chk("t2_done", DONE_CNT, 16'd4);
        chk("t2_busy", BUSY, 1'b1);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        wait_idle(50);
        chk("t2_data", data_err, 0);

        // Random waitrequest; a second START mid-run must be ignored
        clear_stats();
        push_words(16);
        wr_rand = 1'b1;
        start_dma(28'h200, 28'd16, 1'b0);
        repeat (3) tick();
        START_ADR = 28'h999; BUF_SIZE = 28'd5; START = 1'b1;
        tick();
        START = 1'b0;
        wait_idle(1000);
        wr_rand = 1'b0;
        chk("t3_bursts", log_addr.size(), 2);
        if (log_addr.size() >= 2) begin
            chk("t3_addr0", log_addr[0], 28'h200);
            chk("t3_addr1", log_addr[1], 28'h208);
            chk("t3_len1", log_len[1], 7'd8);
        end
        chk("t3_beats", beats, 16);
        chk("t3_stable", stab_err, 0);
        chk("t3_rden", rden_err, 0);
        chk("t3_data", data_err, 0);
        chk("t3_done", DONE_CNT, 16'd5);
`ifdef DMA_WR_STATS_EN
        chk("t3_stall_cnt", stall_cnt, 32'(stalls));
`endif
        tick();

        // STOP during the third beat of the second burst
        clear_stats();
        push_words(32);
        start_dma(28'h300, 28'd32, 1'b0);
        n = 0;
        while (beats < 10 && n < 200) begin
            tick();
            n++;
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        wait_idle(200);
        chk("t4_beats", beats, 16);
        chk("t4_bursts", log_len.size(), 2);
        if (log_len.size() >= 2) chk("t4_len1", log_len[1], 7'd8);
        chk("t4_done", DONE_CNT, 16'd5);
        flush_fifo();

        // Zero-size START
        clear_stats();
        push_words(8);
        start_dma(28'h40, 28'd0, 1'b0);
        repeat (6) tick();
        chk("t5_cfgerr", CFG_ERR, 1'b1);
        chk("t5_busy", BUSY, 1'b0);
        chk("t5_writes", beats + log_addr.size(), 0);
        flush_fifo();

        // Reset during the fifth beat
        clear_stats();
        push_words(32);
        start_dma(28'h400, 28'd32, 1'b0);
        n = 0;
        while (beats < 4 && n < 200) begin
            tick();
            n++;
        end
        RST_N = 1'b0;
        #1;
        chk("t6_write", bus.SDRAM_WRITE, 1'b0);
        chk("t6_rden", bus.FIFO_RD_EN, 1'b0);
        chk("t6_busy", BUSY, 1'b0);
        chk("t6_done", DONE_CNT, 16'd0);
        chk("t6_cfgerr", CFG_ERR, 1'b0);
        chk("t6_addr", bus.SDRAM_ADDRESS, 28'd0);
        chk("t6_bcnt", bus.SDRAM_BURSTCOUNT, 7'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        clear_stats();
        repeat (20) tick();
        chk("t6_no_writes", beats + log_addr.size(), 0);
        chk("t6_idle", BUSY, 1'b0);

        // Fresh run after reset
        flush_fifo();
        clear_stats();
        push_words(8);
        start_dma(28'h500, 28'd8, 1'b0);
        wait_idle(200);
        chk("t7_bursts", log_addr.size(), 1);
        if (log_addr.size() >= 1) chk("t7_addr", log_addr[0], 28'h500);
        chk("t7_beats", beats, 8);
        chk("t7_data", data_err, 0);
        chk("t7_done", DONE_CNT, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
